// File: rtl/gate_chk_pkg.sv
// Shared constants for the two-input gate truth-table checker: state codes,
// reference truth tables and small helpers.
package gate_chk_pkg;

   localparam int NUM_VECTORS = 4;

   // Truth tables are indexed by {A,B}.
   localparam logic [3:0] NOR_TT  = 4'b0001;
   localparam logic [3:0] AND_TT  = 4'b1000;
   localparam logic [3:0] OR_TT   = 4'b1110;
   localparam logic [3:0] NAND_TT = 4'b0111;

   typedef logic [2:0] gc_state_t;

   localparam gc_state_t ST_IDLE   = 3'd0;
   localparam gc_state_t ST_DRIVE  = 3'd1;
   localparam gc_state_t ST_SETTLE = 3'd2;
   localparam gc_state_t ST_SAMPLE = 3'd3;
   localparam gc_state_t ST_DONE   = 3'd4;

   typedef struct packed {
      logic       pass;
      logic [3:0] fail_vec;
      logic [2:0] err_cnt;
   } gc_result_t;

   // Mismatch counter never exceeds the number of vectors.
   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v >= 3'd4) ? 3'd4 : v + 3'd1;
   endfunction

endpackage

// File: rtl/gate_chk_settle_timer.sv
// Settle-time down-counter: loaded while a vector is driven, counts down
// while settling, flags expiry in the last settle cycle.
module gate_chk_settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // A zero count also expires so the sweep can never stall in SETTLE.
   assign expired_o = en_i && (cnt_q <= 4'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps all four {A,B} input pairs through a two-input gate, compares Q
// against EXPECTED_TT and reports pass, per-vector failures and a count.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter logic [3:0]  EXPECTED_TT   = NOR_TT,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       A,
   output logic       B,
   input  logic       Q,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [2:0] err_cnt,
   output logic [2:0] dbg_state_o
);

   gc_state_t  state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic       done_q, done_d;
   gc_result_t res_q, res_d;
   logic       settle_expired;

   gate_chk_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (state_q == ST_DRIVE),
      .en_i     (state_q == ST_SETTLE),
      .expired_o(settle_expired)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      done_d  = 1'b0;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            // start is only looked at here, so it is ignored mid-sweep.
            if (start) begin
               state_d        = ST_DRIVE;
               idx_d          = 2'd0;
               res_d.pass     = 1'b0;
               res_d.fail_vec = 4'd0;
               res_d.err_cnt  = 3'd0;
            end
         end
         ST_DRIVE: begin
            a_d     = idx_q[1];
            b_d     = idx_q[0];
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_expired) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (Q != EXPECTED_TT[idx_q]) begin
               res_d.fail_vec[idx_q] = 1'b1;
               res_d.err_cnt         = sat_inc(res_q.err_cnt);
            end
            if (idx_q == 2'd3) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_DRIVE;
            end
         end
         ST_DONE: begin
            done_d     = 1'b1;
            res_d.pass = (res_q.fail_vec == 4'd0);
            a_d        = 1'b0;
            b_d        = 1'b0;
            idx_d      = 2'd0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end

   assign A           = a_q;
   assign B           = b_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign pass        = res_q.pass;
   assign fail_vec    = res_q.fail_vec;
   assign err_cnt     = res_q.err_cnt;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: four checker instances (NOR/AND expectation on
// a NOR gate, Q stuck low, short settle) driven from a table of sweeps.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] start_v;
  logic [3:0] a_v, b_v, q_v, busy_v, done_v, pass_v;
  logic [3:0] fv_v [4];
  logic [2:0] ec_v [4];
  logic [2:0] st_v [4];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         dut;
    int         settle;
    bit         restart;
    int         exp_edge;
    logic       exp_pass;
    logic [3:0] exp_fv;
    logic [2:0] exp_ec;
  } vec_t;

  vec_t tbl [6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // nor_gate1 on instances 0, 1 and 3; instance 2 sees a stuck-at-0 output
  assign q_v[0] = ~(a_v[0] | b_v[0]);
  assign q_v[1] = ~(a_v[1] | b_v[1]);
  assign q_v[2] = 1'b0;
  assign q_v[3] = ~(a_v[3] | b_v[3]);

  gate_truth_checker #(.EXPECTED_TT(NOR_TT), .SETTLE_CYCLES(2)) dut_nor (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .Q(q_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_vec(fv_v[0]),
    .err_cnt(ec_v[0]), .dbg_state_o(st_v[0]));

  gate_truth_checker #(.EXPECTED_TT(AND_TT), .SETTLE_CYCLES(2)) dut_and (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .Q(q_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_vec(fv_v[1]),
    .err_cnt(ec_v[1]), .dbg_state_o(st_v[1]));

  gate_truth_checker #(.EXPECTED_TT(NOR_TT), .SETTLE_CYCLES(2)) dut_q0 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .Q(q_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_vec(fv_v[2]),
    .err_cnt(ec_v[2]), .dbg_state_o(st_v[2]));

  gate_truth_checker #(.EXPECTED_TT(NOR_TT), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start_v[3]), .A(a_v[3]), .B(b_v[3]), .Q(q_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .fail_vec(fv_v[3]),
    .err_cnt(ec_v[3]), .dbg_state_o(st_v[3]));

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int d);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
  endtask

  // Runs one table row; n counts rising edges after the edge that took start.
  task automatic run_sweep(input int r);
    int d, s, per, n_done, first_done;
    d          = tbl[r].dut;
    s          = tbl[r].settle;
    per        = s + 2;
    n_done     = 0;
    first_done = -1;
    pulse_start(d);
    for (int n = 1; n <= tbl[r].exp_edge + 3; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        chk($sformatf("row%0d busy_early", r), 32'(busy_v[d]), 32'd1);
        chk($sformatf("row%0d pass_clear", r), 32'(pass_v[d]), 32'd0);
        chk($sformatf("row%0d fv_clear", r), 32'(fv_v[d]), 32'd0);
        chk($sformatf("row%0d ec_clear", r), 32'(ec_v[d]), 32'd0);
      end
      if ((n % per == s + 1) && (n < 4 * per)) begin
        chk($sformatf("row%0d ab_at_%0d", r, n), 32'({a_v[d], b_v[d]}), 32'(n / per));
      end
      if (done_v[d] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (n == tbl[r].exp_edge) begin
        chk($sformatf("row%0d busy_end", r), 32'(busy_v[d]), 32'd0);
        chk($sformatf("row%0d ab_end", r), 32'({a_v[d], b_v[d]}), 32'd0);
        chk($sformatf("row%0d pass", r), 32'(pass_v[d]), 32'(tbl[r].exp_pass));
        chk($sformatf("row%0d fail_vec", r), 32'(fv_v[d]), 32'(tbl[r].exp_fv));
        chk($sformatf("row%0d err_cnt", r), 32'(ec_v[d]), 32'(tbl[r].exp_ec));
      end
      start_v[d] = (tbl[r].restart && (n == 2 || n == 8)) ? 1'b1 : 1'b0;
    end
    chk($sformatf("row%0d done_edge", r), 32'(first_done), 32'(tbl[r].exp_edge));
    chk($sformatf("row%0d done_count", r), 32'(n_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("row%0d pass_hold", r), 32'(pass_v[d]), 32'(tbl[r].exp_pass));
    chk($sformatf("row%0d fv_hold", r), 32'(fv_v[d]), 32'(tbl[r].exp_fv));
    chk($sformatf("row%0d ec_hold", r), 32'(ec_v[d]), 32'(tbl[r].exp_ec));
    chk($sformatf("row%0d state_idle", r), 32'(st_v[d]), 32'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n_done, cnt;
    tbl[0] = '{0, 2, 1'b0, 17, 1'b1, 4'b0000, 3'd0};
    tbl[1] = '{1, 2, 1'b0, 17, 1'b0, 4'b1001, 3'd2};
    tbl[2] = '{1, 2, 1'b0, 17, 1'b0, 4'b1001, 3'd2};
    tbl[3] = '{2, 2, 1'b0, 17, 1'b0, 4'b0001, 3'd1};
    tbl[4] = '{0, 2, 1'b1, 17, 1'b1, 4'b0000, 3'd0};
    tbl[5] = '{3, 1, 1'b0, 13, 1'b1, 4'b0000, 3'd0};

    start_v = 4'd0;
    rst     = 1'b1;
    #1;
    chk("reset_busy", 32'(busy_v[0]), 32'd0);
    chk("reset_ab", 32'({a_v[0], b_v[0]}), 32'd0);
    chk("reset_done", 32'(done_v[0]), 32'd0);
    chk("reset_pass", 32'(pass_v[0]), 32'd0);
    chk("reset_fv", 32'(fv_v[0]), 32'd0);
    chk("reset_ec", 32'(ec_v[0]), 32'd0);
    chk("reset_state", 32'(st_v[0]), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 6; r++) begin
      run_sweep(r);
    end

    // Reset during SETTLE of vector 10 (DRIVE at edge 8, SETTLE after edge 9).
    pulse_start(0);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_state_settle", 32'(st_v[0]), 32'(ST_SETTLE));
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_ab", 32'({a_v[0], b_v[0]}), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_pass", 32'(pass_v[0]), 32'd0);
    chk("abort_fv", 32'(fv_v[0]), 32'd0);
    chk("abort_ec", 32'(ec_v[0]), 32'd0);
    chk("abort_state", 32'(st_v[0]), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done_v[0] === 1'b1) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    run_sweep(0);

    // Back-to-back sweeps with SETTLE_CYCLES=1: restart in the cycle after done.
    pulse_start(3);
    cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done_v[3] === 1'b1) begin
        cnt = n;
        break;
      end
    end
    chk("b2b_first_done_edge", 32'(cnt), 32'd13);
    start_v[3] = 1'b1;
    @(posedge clk);
    #1 start_v[3] = 1'b0;
    chk("b2b_second_accepted", 32'(busy_v[3]), 32'd1);
    cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done_v[3] === 1'b1) begin
        cnt = n;
        break;
      end
    end
    chk("b2b_second_done_edge", 32'(cnt), 32'd13);
    chk("b2b_pass", 32'(pass_v[3]), 32'd1);
    chk("b2b_fv", 32'(fv_v[3]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
